// File: rtl/sump_cmd_sender_pkg.sv
// Shared types and opcode constants for the SUMP host-side command sender.
// Holds the 40-bit command layout and the byte-count rule for short/long commands.
package sump_cmd_sender_pkg;

    localparam logic [7:0] OP_RESET = 8'h00;
    localparam logic [7:0] OP_RUN   = 8'h01;
    localparam logic [7:0] OP_ID    = 8'h02;
    localparam logic [7:0] OP_XON   = 8'h11;
    localparam logic [7:0] OP_XOFF  = 8'h13;
    localparam logic [7:0] OP_FLAGS = 8'h82;
    localparam int LONG_CMD_BIT     = 7;

    typedef struct packed {
        logic [7:0] byte3;
        logic [7:0] byte2;
        logic [7:0] byte1;
        logic [7:0] byte0;
        logic [7:0] opcode;
    } sump_cmd_t;

    function automatic logic [2:0] cmd_nbytes(input logic [7:0] op);
        return op[LONG_CMD_BIT] ? 3'd5 : 3'd1;
    endfunction

endpackage

// File: rtl/sump_cmd_sender_if.sv
// Command/serial bundle between a command source and the SUMP sender.
// master: drives cmd/send/hold, sees tx/busy/byte_done; slave: the sender.
interface sump_cmd_sender_if;

    logic [39:0] cmd;
    logic        send;
    logic        hold;
    logic        tx;
    logic        busy;
    logic        byte_done;

    modport master (
        output cmd, send, hold,
        input  tx, busy, byte_done
    );

    modport slave (
        input  cmd, send, hold,
        output tx, busy, byte_done
    );

endinterface

// File: rtl/sump_cmd_sender.sv
// Serializes a SUMP command (opcode then byte0..byte3) onto an 8N1 line.
// Ports: clock, reset (sync, active-high), bus (slave: cmd/send/hold in, tx/busy/byte_done out).
module sump_cmd_sender #(
    parameter int FREQ = 100000000,
    parameter int RATE = 115200
) (
    input logic              clock,
    input logic              reset,
    sump_cmd_sender_if.slave bus
);

    import sump_cmd_sender_pkg::*;

    localparam int          BITTIME = FREQ / RATE;
    localparam logic [15:0] TLOAD   = 16'(BITTIME - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;

    logic [2:0]  state;
    logic [2:0]  state_n;
    logic [15:0] timer;
    logic [2:0]  bitidx;
    logic [2:0]  nleft;
    logic [39:0] shreg;
    logic [7:0]  cur;
    logic        tick;
    logic        last;
    logic        tx;
    logic        busy;
    logic        byte_done;

    assign tick = (timer == 16'd0);
    assign last = (nleft == 3'd1);
    assign cur  = shreg[7:0];

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (bus.send) state_n = S_START;
            S_START: if (tick) state_n = S_DATA;
            S_DATA:  if (tick && bitidx == 3'd7) state_n = S_STOP;
            S_STOP: begin
                if (tick) begin
                    if (last)          state_n = S_IDLE;
                    else if (bus.hold) state_n = S_WAIT;
                    else               state_n = S_START;
                end
            end
            S_WAIT:  if (!bus.hold) state_n = S_START;
            default: state_n = S_IDLE;
        endcase
    end

    // Datapath: bit timer, bit index, shift register, remaining-byte count.
    // The timer is reloaded whenever a new bit period begins.
    always_ff @(posedge clock) begin
        if (reset) begin
            timer  <= 16'd0;
            bitidx <= 3'd0;
            nleft  <= 3'd0;
            shreg  <= 40'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.send) begin
                        shreg <= bus.cmd;
                        nleft <= cmd_nbytes(bus.cmd[7:0]);
                        timer <= TLOAD;
                    end
                end
                S_START: begin
                    timer <= tick ? TLOAD : timer - 16'd1;
                end
                S_DATA: begin
                    if (tick) begin
                        timer  <= TLOAD;
                        bitidx <= bitidx + 3'd1;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        shreg <= shreg >> 8;
                        nleft <= nleft - 3'd1;
                        timer <= (state_n == S_START) ? TLOAD : 16'd0;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                S_WAIT: begin
                    if (!bus.hold) timer <= TLOAD;
                end
                default: begin
                    timer  <= 16'd0;
                    bitidx <= 3'd0;
                end
            endcase
        end
    end

    always_comb begin
        tx        = 1'b1;
        busy      = (state != S_IDLE);
        byte_done = (state == S_STOP) && tick;
        unique case (state)
            S_START: tx = 1'b0;
            S_DATA:  tx = cur[bitidx];
            default: tx = 1'b1;
        endcase
    end

    assign bus.tx        = tx;
    assign bus.busy      = busy;
    assign bus.byte_done = byte_done;

endmodule

// File: tb/tb_sump_cmd_sender.sv
// Directed bench for sump_cmd_sender at BITTIME=10 with a UART-decoding scoreboard.
// Ports exercised: clock, reset, cmd, send, hold, tx, busy, byte_done.
module tb_sump_cmd_sender;

    logic clock;
    logic reset;

    sump_cmd_sender_if bus ();

    sump_cmd_sender #(
        .FREQ(1000),
        .RATE(100)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors;
    int miscompares;
    int done_cnt;
    logic [7:0] sb[$];

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // byte_done pulse counter
    always @(negedge clock) begin
        if (!reset && bus.byte_done === 1'b1) done_cnt++;
    end

    // Line monitor: finds a start edge, samples mid-bit, pops the scoreboard.
    logic       tx_prev;
    logic       mact;
    int         mcnt;
    logic [9:0] msh;
    logic [7:0] expb;

    always @(negedge clock) begin
        if (reset) begin
            mact = 1'b0;
        end else if (!mact) begin
            if (tx_prev === 1'b1 && bus.tx === 1'b0) begin
                mact = 1'b1;
                mcnt = 0;
            end
        end else begin
            mcnt++;
            if (mcnt % 10 == 5) begin
                msh[mcnt/10] = bus.tx;
                if (mcnt == 95) begin
                    mact = 1'b0;
                    check("start_bit", 64'(msh[0]), 64'd0);
                    check("stop_bit", 64'(msh[9]), 64'd1);
                    if (sb.size() == 0) begin
                        check("unexpected_byte", 64'(msh[8:1]), 64'hx);
                    end else begin
                        expb = sb.pop_front();
                        check("wire_byte", 64'(msh[8:1]), 64'(expb));
                    end
                end
            end
        end
        tx_prev = bus.tx;
    end

    task automatic send_cmd(input logic [39:0] c);
        @(posedge clock);
        #1;
        bus.cmd  = c;
        bus.send = 1'b1;
        @(posedge clock);
        #1;
        bus.send = 1'b0;
    endtask

    // Counts busy cycles from now; optionally pulses a second send mid-frame.
    task automatic wait_idle(output int cycles, input int ovl_at,
                             input logic [39:0] ovl_cmd);
        cycles = 0;
        for (int i = 0; i < 2000; i++) begin
            if (bus.busy !== 1'b1) break;
            cycles++;
            if (i == ovl_at) begin
                bus.cmd  = ovl_cmd;
                bus.send = 1'b1;
            end else begin
                bus.send = 1'b0;
            end
            @(posedge clock);
            #1;
        end
        bus.send = 1'b0;
    endtask

    int cyc;
    int d0;

    initial begin
        vectors     = 0;
        miscompares = 0;
        done_cnt    = 0;
        mact        = 1'b0;
        tx_prev     = 1'b1;
        bus.cmd     = 40'd0;
        bus.send    = 1'b0;
        bus.hold    = 1'b0;
        reset       = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_tx", 64'(bus.tx), 64'd1);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.byte_done), 64'd0);
        reset = 1'b0;
        repeat (3) @(posedge clock);

        // Short command
        d0 = done_cnt;
        sb.push_back(8'h02);
        send_cmd(40'h02);
        check("short_tx_fall", 64'(bus.tx), 64'd0);
        wait_idle(cyc, -1, 40'd0);
        check("short_busy_len", 64'(cyc), 64'd100);
        check("short_done_cnt", 64'(done_cnt - d0), 64'd1);
        repeat (5) @(posedge clock);

        // Long command, back-to-back bytes
        d0 = done_cnt;
        sb.push_back(8'h82);
        sb.push_back(8'h3C);
        sb.push_back(8'h00);
        sb.push_back(8'h00);
        sb.push_back(8'h00);
        send_cmd({32'h0000003C, 8'h82});
        wait_idle(cyc, -1, 40'd0);
        check("long_busy_len", 64'(cyc), 64'd500);
        check("long_done_cnt", 64'(done_cnt - d0), 64'd5);
        repeat (5) @(posedge clock);

        // Overlapping send is ignored
        d0 = done_cnt;
        sb.push_back(8'h11);
        send_cmd(40'h11);
        wait_idle(cyc, 19, {32'hFFFFFFFF, 8'h82});
        check("ovl_busy_len", 64'(cyc), 64'd100);
        check("ovl_done_cnt", 64'(done_cnt - d0), 64'd1);
        repeat (20) @(posedge clock);
        #1;
        check("ovl_idle", 64'(bus.busy), 64'd0);

        // Flow control during byte0
        d0 = done_cnt;
        sb.push_back(8'h82);
        sb.push_back(8'h11);
        sb.push_back(8'h22);
        sb.push_back(8'h33);
        sb.push_back(8'h44);
        send_cmd({32'h44332211, 8'h82});
        repeat (30) @(posedge clock);
        #1;
        bus.hold = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (done_cnt - d0 >= 1) break;
            @(posedge clock);
            #1;
        end
        repeat (30) @(posedge clock);
        #1;
        check("hold_tx", 64'(bus.tx), 64'd1);
        check("hold_busy", 64'(bus.busy), 64'd1);
        check("hold_done_cnt", 64'(done_cnt - d0), 64'd1);
        check("hold_sb_left", 64'(sb.size()), 64'd4);
        bus.hold = 1'b0;
        @(posedge clock);
        #1;
        check("release_start", 64'(bus.tx), 64'd0);
        wait_idle(cyc, -1, 40'd0);
        check("hold_total_done", 64'(done_cnt - d0), 64'd5);
        check("hold_sb_empty", 64'(sb.size()), 64'd0);
        repeat (5) @(posedge clock);

        // Reset in the middle of a data bit
        send_cmd(40'hA5);
        repeat (35) @(posedge clock);
        #1;
        check("mid_busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mrst_tx", 64'(bus.tx), 64'd1);
        check("mrst_busy", 64'(bus.busy), 64'd0);
        check("mrst_done", 64'(bus.byte_done), 64'd0);
        reset = 1'b0;
        repeat (12) @(posedge clock);

        d0 = done_cnt;
        sb.push_back(8'h55);
        send_cmd(40'h55);
        check("fresh_tx_fall", 64'(bus.tx), 64'd0);
        wait_idle(cyc, -1, 40'd0);
        check("fresh_busy_len", 64'(cyc), 64'd100);
        check("fresh_done_cnt", 64'(done_cnt - d0), 64'd1);
        repeat (5) @(posedge clock);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
